// File: rtl/hazard_pipe_tracker_if.sv
// Instruction-descriptor handshake into the hazard pipe tracker.
// The master offers descriptors; the slave (tracker) returns in_ready.
interface hazard_pipe_tracker_if #(
  parameter int unsigned REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_src1;
  logic [REG_AW-1:0] in_src2;
  logic [REG_AW-1:0] in_dst;
  logic              in_wr;
  logic              in_load;

  modport master (
    output in_valid, in_src1, in_src2, in_dst, in_wr, in_load,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_dst, in_wr, in_load,
    output in_ready
  );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// ID/EX/MEM/WB descriptor pipeline driven by an external hazard resolver's stall/flush requests,
// with retire/bubble counters and a sticky stall watchdog.
module hazard_pipe_tracker #(
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  hazard_pipe_tracker_if.slave in_bus,
  input  logic              stall_req,
  input  logic              flush_req,
  output logic              id_valid,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] id_src1,
  output logic [REG_AW-1:0] id_src2,
  output logic [REG_AW-1:0] ex_dst,
  output logic [REG_AW-1:0] mem_dst,
  output logic [REG_AW-1:0] wb_dst,
  output logic              ex_wr,
  output logic              mem_wr,
  output logic              wb_wr,
  output logic              ex_load,
  output logic              wb_we,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              stall_timeout
);

  localparam logic [7:0] MaxRun = 8'(MAX_STALL);

  logic              id_valid_q, id_valid_d, id_wr_q, id_wr_d, id_load_q, id_load_d;
  logic [REG_AW-1:0] id_src1_q, id_src1_d, id_src2_q, id_src2_d, id_dst_q, id_dst_d;
  logic              ex_valid_q, ex_valid_d, ex_wr_q, ex_wr_d, ex_load_q, ex_load_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
  logic              mem_valid_q, mem_valid_d, mem_wr_q, mem_wr_d;
  logic [REG_AW-1:0] mem_dst_q, mem_dst_d;
  logic              wb_valid_q, wb_valid_d, wb_wr_q, wb_wr_d;
  logic [REG_AW-1:0] wb_dst_q, wb_dst_d;
  logic [CNT_W-1:0]  retire_q, retire_d, bubble_q, bubble_d;
  logic [7:0]        run_q, run_d;
  logic              timeout_q, timeout_d;

  assign in_bus.in_ready = ena & ~stall_req & ~flush_req;

  always_comb begin
    id_valid_d  = id_valid_q;
    id_src1_d   = id_src1_q;
    id_src2_d   = id_src2_q;
    id_dst_d    = id_dst_q;
    id_wr_d     = id_wr_q;
    id_load_d   = id_load_q;
    ex_valid_d  = ex_valid_q;
    ex_dst_d    = ex_dst_q;
    ex_wr_d     = ex_wr_q;
    ex_load_d   = ex_load_q;
    mem_valid_d = mem_valid_q;
    mem_dst_d   = mem_dst_q;
    mem_wr_d    = mem_wr_q;
    wb_valid_d  = wb_valid_q;
    wb_dst_d    = wb_dst_q;
    wb_wr_d     = wb_wr_q;
    retire_d    = retire_q;
    bubble_d    = bubble_q;
    run_d       = run_q;
    timeout_d   = timeout_q;

    if (ena) begin
      // MEM and WB always advance; EX contents move on even when being squashed.
      mem_valid_d = ex_valid_q;
      mem_dst_d   = ex_dst_q;
      mem_wr_d    = ex_wr_q;
      wb_valid_d  = mem_valid_q;
      wb_dst_d    = mem_dst_q;
      wb_wr_d     = mem_wr_q;
      if (wb_valid_q) retire_d = retire_q + CNT_W'(1);

      if (flush_req || stall_req) begin
        ex_valid_d = 1'b0;
        ex_dst_d   = '0;
        ex_wr_d    = 1'b0;
        ex_load_d  = 1'b0;
      end else begin
        ex_valid_d = id_valid_q;
        ex_dst_d   = id_dst_q;
        ex_wr_d    = id_wr_q;
        ex_load_d  = id_load_q;
      end

      if (flush_req || (!stall_req && !in_bus.in_valid)) begin
        id_valid_d = 1'b0;
        id_src1_d  = '0;
        id_src2_d  = '0;
        id_dst_d   = '0;
        id_wr_d    = 1'b0;
        id_load_d  = 1'b0;
      end else if (!stall_req) begin
        id_valid_d = 1'b1;
        id_src1_d  = in_bus.in_src1;
        id_src2_d  = in_bus.in_src2;
        id_dst_d   = in_bus.in_dst;
        id_wr_d    = in_bus.in_wr;
        id_load_d  = in_bus.in_load;
      end

      if (stall_req && !flush_req) begin
        bubble_d = bubble_q + CNT_W'(1);
        run_d    = (run_q == MaxRun) ? run_q : run_q + 8'd1;
        if (run_d == MaxRun) timeout_d = 1'b1;
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q  <= 1'b0;
      id_src1_q   <= '0;
      id_src2_q   <= '0;
      id_dst_q    <= '0;
      id_wr_q     <= 1'b0;
      id_load_q   <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_dst_q    <= '0;
      ex_wr_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dst_q   <= '0;
      mem_wr_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dst_q    <= '0;
      wb_wr_q     <= 1'b0;
      retire_q    <= '0;
      bubble_q    <= '0;
      run_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_src1_q   <= id_src1_d;
      id_src2_q   <= id_src2_d;
      id_dst_q    <= id_dst_d;
      id_wr_q     <= id_wr_d;
      id_load_q   <= id_load_d;
      ex_valid_q  <= ex_valid_d;
      ex_dst_q    <= ex_dst_d;
      ex_wr_q     <= ex_wr_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_dst_q   <= mem_dst_d;
      mem_wr_q    <= mem_wr_d;
      wb_valid_q  <= wb_valid_d;
      wb_dst_q    <= wb_dst_d;
      wb_wr_q     <= wb_wr_d;
      retire_q    <= retire_d;
      bubble_q    <= bubble_d;
      run_q       <= run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign id_valid      = id_valid_q;
  assign ex_valid      = ex_valid_q;
  assign mem_valid     = mem_valid_q;
  assign wb_valid      = wb_valid_q;
  assign id_src1       = id_src1_q;
  assign id_src2       = id_src2_q;
  assign ex_dst        = ex_dst_q;
  assign mem_dst       = mem_dst_q;
  assign wb_dst        = wb_dst_q;
  assign ex_wr         = ex_wr_q;
  assign mem_wr        = mem_wr_q;
  assign wb_wr         = wb_wr_q;
  assign ex_load       = ex_load_q;
  assign wb_we         = wb_valid_q & wb_wr_q;
  assign retire_cnt    = retire_q;
  assign bubble_cnt    = bubble_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Bench for hazard_pipe_tracker: directed scenarios plus random traffic checked against a
// stage-list model of the pipeline.
module tb_hazard_pipe_tracker;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned MS = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic stall_req = 1'b0;
  logic flush_req = 1'b0;

  logic          id_valid, ex_valid, mem_valid, wb_valid;
  logic [AW-1:0] id_src1, id_src2, ex_dst, mem_dst, wb_dst;
  logic          ex_wr, mem_wr, wb_wr, ex_load, wb_we, stall_timeout;
  logic [CW-1:0] retire_cnt, bubble_cnt;

  hazard_pipe_tracker_if #(.REG_AW(AW)) bus ();

  hazard_pipe_tracker #(.REG_AW(AW), .CNT_W(CW), .MAX_STALL(MS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_bus(bus.slave),
    .stall_req(stall_req), .flush_req(flush_req),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .id_src1(id_src1), .id_src2(id_src2), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_load(ex_load), .wb_we(wb_we),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // Model: m[0]=ID, m[1]=EX, m[2]=MEM, m[3]=WB.
  typedef struct {
    bit v; bit [AW-1:0] s1; bit [AW-1:0] s2; bit [AW-1:0] d; bit wr; bit ld;
  } desc_t;
  desc_t m[4];
  int    m_retire, m_bubble, m_run;
  bit    m_to;
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m[i] = '{default: 0};
    m_retire = 0; m_bubble = 0; m_run = 0; m_to = 0;
  endtask

  task automatic model_step();
    desc_t e;
    e = '{default: 0};
    if (!ena) return;
    if (m[3].v) m_retire = (m_retire + 1) % 256;
    m[3] = m[2];
    m[2] = m[1];
    if (flush_req) begin
      m[1] = e; m[0] = e;
    end else if (stall_req) begin
      m[1] = e; m_bubble = (m_bubble + 1) % 256;
    end else begin
      m[1] = m[0];
      m[0] = bus.in_valid ? '{1'b1, bus.in_src1, bus.in_src2, bus.in_dst, bus.in_wr, bus.in_load}
                          : e;
    end
    if (stall_req && !flush_req) begin
      if (m_run < MS) m_run++;
      if (m_run == MS) m_to = 1'b1;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic put(input bit v, input bit [AW-1:0] s1, input bit [AW-1:0] s2,
                     input bit [AW-1:0] d, input bit wr, input bit ld);
    bus.in_valid = v; bus.in_src1 = s1; bus.in_src2 = s2;
    bus.in_dst = d; bus.in_wr = wr; bus.in_load = ld;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ena = 1'b1; stall_req = 1'b0; flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 4'(i), 4'(i + 1), 4'(i + 2), 1'b1, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if ({id_valid, ex_valid, mem_valid, wb_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_async valids got %b want 0000", {id_valid, ex_valid, mem_valid, wb_valid});
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({retire_cnt, bubble_cnt, stall_timeout} !== 17'b0) begin
      n_fail++; $display("FAIL reset_counters got %h want 0", {retire_cnt, bubble_cnt, stall_timeout});
    end
    rst_n = 1'b1;
    put(1'b0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_streaming();
    int base;
    base = m_retire;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) put(1'b1, 0, 0, 4'(k), 1'b1, 1'b0);
      else put(1'b0, 0, 0, 0, 0, 0);
      tick();
      if (k >= 4 && k <= 7) begin
        n_cmp++;
        if (wb_dst !== 4'(k - 3) || wb_we !== 1'b1) begin
          n_fail++; $display("FAIL stream_wb edge %0d got dst=%0d we=%b want dst=%0d we=1",
                             k, wb_dst, wb_we, k - 3);
        end
      end
    end
    n_cmp++;
    if (retire_cnt !== 8'(base + 4)) begin
      n_fail++; $display("FAIL stream_retire got %0d want %0d", retire_cnt, base + 4);
    end
  endtask

  task automatic test_load_use();
    int bb;
    bb = m_bubble;
    put(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
    tick();
    put(1'b1, 4'd5, 4'd2, 4'd6, 1'b1, 1'b0);
    tick();
    stall_req = m[1].v && m[1].ld && m[0].v && (m[0].s1 == m[1].d);
    put(1'b1, 4'd1, 4'd1, 4'd7, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL loaduse_in_ready got %b want 0", bus.in_ready);
    end
    tick();
    stall_req = 1'b0;
    n_cmp++;
    if ({id_valid, id_src1, ex_valid, mem_dst, ex_load} !== {1'b1, 4'd5, 1'b0, 4'd5, 1'b0}) begin
      n_fail++; $display("FAIL loaduse_hold got id=%b/%0d ex_v=%b mem_dst=%0d want id=1/5 ex_v=0 mem_dst=5",
                         id_valid, id_src1, ex_valid, mem_dst);
    end
    n_cmp++;
    if (bubble_cnt !== 8'(bb + 1)) begin
      n_fail++; $display("FAIL loaduse_bubble got %0d want %0d", bubble_cnt, bb + 1);
    end
    tick();
    n_cmp++;
    if ({ex_valid, ex_dst, id_valid, id_src1} !== {1'b1, 4'd6, 1'b1, 4'd1}) begin
      n_fail++; $display("FAIL loaduse_order got ex=%b/%0d id=%b/%0d want ex=1/6 id=1/1",
                         ex_valid, ex_dst, id_valid, id_src1);
    end
    put(1'b0, 0, 0, 0, 0, 0);
    repeat (4) tick();
  endtask

  task automatic test_flush();
    int base, bb;
    base = m_retire; bb = m_bubble;
    for (int k = 1; k <= 4; k++) begin
      put(1'b1, 0, 0, 4'(8 + k), 1'b1, 1'b0);
      tick();
    end
    put(1'b0, 0, 0, 0, 0, 0);
    stall_req = 1'b1; flush_req = 1'b1;
    tick();
    stall_req = 1'b0; flush_req = 1'b0;
    n_cmp++;
    if ({id_valid, ex_valid, mem_valid, mem_dst, wb_valid, wb_dst} !==
        {1'b0, 1'b0, 1'b1, 4'd11, 1'b1, 4'd10}) begin
      n_fail++; $display("FAIL flush_stages got id=%b ex=%b mem=%b/%0d wb=%b/%0d want 0 0 1/11 1/10",
                         id_valid, ex_valid, mem_valid, mem_dst, wb_valid, wb_dst);
    end
    n_cmp++;
    if (bubble_cnt !== 8'(bb)) begin
      n_fail++; $display("FAIL flush_bubble got %0d want %0d", bubble_cnt, bb);
    end
    repeat (3) tick();
    n_cmp++;
    if (retire_cnt !== 8'(base + 3)) begin
      n_fail++; $display("FAIL flush_retire got %0d want %0d", retire_cnt, base + 3);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    stall_req = 1'b1;
    repeat (14) tick();
    stall_req = 1'b0;
    tick();
    n_cmp++;
    if (stall_timeout !== 1'b0) begin
      n_fail++; $display("FAIL wdog_14 got %b want 0", stall_timeout);
    end
    stall_req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k >= 14) begin
        n_cmp++;
        if (stall_timeout !== (k == 15)) begin
          n_fail++; $display("FAIL wdog_edge%0d got %b want %b", k, stall_timeout, k == 15);
        end
      end
    end
    stall_req = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({stall_timeout, bubble_cnt} !== {1'b1, 8'd29}) begin
      n_fail++; $display("FAIL wdog_sticky got to=%b bub=%0d want to=1 bub=29", stall_timeout, bubble_cnt);
    end
  endtask

  task automatic test_ena_wrap();
    do_reset();
    put(1'b1, 4'd3, 4'd4, 4'd9, 1'b1, 1'b0);
    repeat (2) tick();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1);
      stall_req = 1'($urandom);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL ena0_in_ready got %b want 0", bus.in_ready);
      end
      tick();
      n_cmp++;
      if ({id_valid, ex_valid, mem_valid, ex_dst, bubble_cnt} !== {m[0].v, m[1].v, m[2].v, m[1].d, 8'(m_bubble)}) begin
        n_fail++; $display("FAIL ena0_frozen got %b%b%b dst=%0d bub=%0d want 110 dst=9 bub=0",
                           id_valid, ex_valid, mem_valid, ex_dst, bubble_cnt);
      end
    end
    ena = 1'b1; stall_req = 1'b0;
    do_reset();
    for (int k = 1; k <= 260; k++) begin
      if (k <= 256) put(1'b1, 0, 0, 4'(k), 1'b1, 1'b0);
      else put(1'b0, 0, 0, 0, 0, 0);
      tick();
      if (k == 259 || k == 260) begin
        n_cmp++;
        if (retire_cnt !== ((k == 259) ? 8'd255 : 8'd0)) begin
          n_fail++; $display("FAIL wrap_retire edge %0d got %0d want %0d", k, retire_cnt,
                             (k == 259) ? 255 : 0);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [45:0] got, exp;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ena       = ($urandom_range(9) != 0);
      stall_req = ($urandom_range(4) == 0);
      flush_req = ($urandom_range(9) == 0);
      put(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      #1;
      n_cmp++;
      if (bus.in_ready !== (ena & ~stall_req & ~flush_req)) begin
        n_fail++; $display("FAIL rand_in_ready cyc %0d got %b want %b", k, bus.in_ready,
                           ena & ~stall_req & ~flush_req);
      end
      tick();
      got = {id_valid, ex_valid, mem_valid, wb_valid, id_src1, id_src2, ex_dst, mem_dst, wb_dst,
             ex_wr, mem_wr, wb_wr, ex_load, wb_we, retire_cnt, bubble_cnt, stall_timeout};
      exp = {m[0].v, m[1].v, m[2].v, m[3].v, m[0].s1, m[0].s2, m[1].d, m[2].d, m[3].d,
             m[1].wr, m[2].wr, m[3].wr, m[1].ld, m[3].v & m[3].wr, 8'(m_retire), 8'(m_bubble), m_to};
      n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rand_state cyc %0d got %h want %h", k, got, exp);
      end
    end
    ena = 1'b1; stall_req = 1'b0; flush_req = 1'b0;
  endtask

  initial begin
    model_clear();
    put(1'b0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_streaming();
    test_load_use();
    test_flush();
    test_watchdog();
    test_ena_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
